// File: rtl/stack_rf_pkg.sv
// Shared definitions for the operand stack: opcode encoding, write-data
// selects and default geometry.
package stack_rf_pkg;

  localparam int STACK_DEPTH = 14;
  localparam int STACK_WIDTH = 8;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    PUSH = 3'd1,
    REPL = 3'd2,
    BIN  = 3'd3,
    POP  = 3'd4,
    DUP  = 3'd5,
    SWAP = 3'd6,
    POP2 = 3'd7
  } stack_op_t;

  // Encodings inherited from the fixed 14 x 8 stack register file.
  localparam stack_op_t ADV_1 = PUSH;
  localparam stack_op_t ADV_0 = REPL;
  localparam stack_op_t DES_1 = BIN;

  // Source of the data on write port 0.
  typedef enum logic [1:0] {
    WSEL_DI  = 2'd0,
    WSEL_TOS = 2'd1,
    WSEL_NOS = 2'd2
  } wr_sel_t;

endpackage

// File: rtl/stack_ctl.sv
// Combinational stack-op decode: legality, next stack pointer, write-port
// enables/indices and error classification, all from the pre-edge sp.
module stack_ctl
  import stack_rf_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  stack_op_t         op,
  input  logic              we,
  input  logic [CW-1:0]     sp,
  output logic              legal,
  output logic [CW-1:0]     sp_next,
  output logic              wr0_en,
  output logic [IW-1:0]     wr0_idx,
  output wr_sel_t           wr0_sel,
  output logic              wr1_en,
  output logic [IW-1:0]     wr1_idx,
  output logic              ovf,
  output logic              unf
);

  logic has1, has2, is_full;

  assign has1    = (sp >= CW'(1));
  assign has2    = (sp >= CW'(2));
  assign is_full = (sp == CW'(DEPTH));

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    legal   = 1'b0;
    sp_next = sp;
    wr0_en  = 1'b0;
    wr0_idx = '0;
    wr0_sel = WSEL_DI;
    wr1_en  = 1'b0;
    wr1_idx = '0;
    ovf     = 1'b0;
    unf     = 1'b0;

    if (we) begin
      // Index arithmetic lives only inside each guard, so sp-1/sp-2 never go negative.
      unique case (op)
        NOP: legal = 1'b1;
        PUSH: begin
          if (!is_full) begin
            legal   = 1'b1;
            wr0_en  = 1'b1;
            wr0_idx = IW'(sp);
            sp_next = sp + CW'(1);
          end else begin
            ovf = 1'b1;
          end
        end
        REPL: begin
          if (has1) begin
            legal   = 1'b1;
            wr0_en  = 1'b1;
            wr0_idx = IW'(sp - CW'(1));
          end else begin
            unf = 1'b1;
          end
        end
        BIN: begin
          if (has2) begin
            legal   = 1'b1;
            wr0_en  = 1'b1;
            wr0_idx = IW'(sp - CW'(2));
            sp_next = sp - CW'(1);
          end else begin
            unf = 1'b1;
          end
        end
        POP: begin
          if (has1) begin
            legal   = 1'b1;
            sp_next = sp - CW'(1);
          end else begin
            unf = 1'b1;
          end
        end
        DUP: begin
          if (!has1) begin
            unf = 1'b1;
          end else if (is_full) begin
            ovf = 1'b1;
          end else begin
            legal   = 1'b1;
            wr0_en  = 1'b1;
            wr0_idx = IW'(sp);
            wr0_sel = WSEL_TOS;
            sp_next = sp + CW'(1);
          end
        end
        SWAP: begin
          if (has2) begin
            legal   = 1'b1;
            wr0_en  = 1'b1;
            wr0_idx = IW'(sp - CW'(1));
            wr0_sel = WSEL_NOS;
            wr1_en  = 1'b1;
            wr1_idx = IW'(sp - CW'(2));
          end else begin
            unf = 1'b1;
          end
        end
        POP2: begin
          if (has2) begin
            legal   = 1'b1;
            sp_next = sp - CW'(2);
          end else begin
            unf = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/stack_rf.sv
// Parametrised operand stack with internal stack pointer, two-port storage
// (second port used by SWAP), occupancy status and sticky error flags.
module stack_rf
  import stack_rf_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  stack_op_t        op,
  input  logic [WIDTH-1:0] di,
  input  logic             clr_err,
  output logic [WIDTH-1:0] do_a,
  output logic [WIDTH-1:0] do_b,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] core_q [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             legal, wr0_en, wr1_en, ovf, unf;
  logic [CW-1:0]    sp_next;
  logic [IW-1:0]    wr0_idx, wr1_idx, tos_idx, nos_idx;
  wr_sel_t          wr0_sel;
  logic [WIDTH-1:0] tos_raw, nos_raw, wr0_data;
  logic             has1, has2;

  stack_ctl #(.DEPTH(DEPTH), .CW(CW), .IW(IW)) u_ctl (
    .op      (op),
    .we      (we),
    .sp      (sp_q),
    .legal   (legal),
    .sp_next (sp_next),
    .wr0_en  (wr0_en),
    .wr0_idx (wr0_idx),
    .wr0_sel (wr0_sel),
    .wr1_en  (wr1_en),
    .wr1_idx (wr1_idx),
    .ovf     (ovf),
    .unf     (unf)
  );

  assign has1    = (sp_q >= CW'(1));
  assign has2    = (sp_q >= CW'(2));
  assign tos_idx = has1 ? IW'(sp_q - CW'(1)) : '0;
  assign nos_idx = has2 ? IW'(sp_q - CW'(2)) : '0;
  assign tos_raw = core_q[tos_idx];
  assign nos_raw = core_q[nos_idx];

  always_comb begin
    wr0_data = di;
    unique case (wr0_sel)
      WSEL_TOS: wr0_data = tos_raw;
      WSEL_NOS: wr0_data = nos_raw;
      default:  wr0_data = di;
    endcase
  end

  // A new error on the same edge as clr_err wins.
  always_comb begin
    sp_d  = legal ? sp_next : sp_q;
    ovf_d = ovf | (ovf_q & ~clr_err);
    unf_d = unf | (unf_q & ~clr_err);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: storage has no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr1_en) core_q[wr1_idx] <= tos_raw;
    if (wr0_en) core_q[wr0_idx] <= wr0_data;
  end

  assign do_a      = has1 ? tos_raw : '0;
  assign do_b      = has2 ? nos_raw : '0;
  assign count     = sp_q;
  assign empty     = (sp_q == '0);
  assign full      = (sp_q == CW'(DEPTH));
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
